// File: rtl/hex_display_scanner.sv
// Four-digit common-anode hex display scanner with per-slot dead-time and frame-synchronous load.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_display_scanner #(
  parameter int unsigned REFRESH_CYCLES = 1024,
  parameter int unsigned DEAD_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);
  localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_CYCLES - 1);
  localparam logic [CntW-1:0] CntDead = CntW'(DEAD_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     hold_q, hold_d;
  logic            pend_q, pend_d;
  logic            xfer_q, xfer_d;
  logic            ack_q;
  logic [3:0]      char_q, char_d;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (cnt_q == CntMax);
  assign frame_end = slot_end && (idx_q == 2'd0);

  always_comb begin
    cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
    idx_d  = slot_end ? idx_q - 2'd1 : idx_q;
    hold_d = hold_q;
    pend_d = pend_q;
    disp_d = disp_q;
    xfer_d = 1'b0;

    if (load) begin
      hold_d = data_in;
      pend_d = 1'b1;
    end

    // A load coinciding with the frame boundary bypasses hold so it is not a frame late.
    if (frame_end) begin
      if (load) begin
        disp_d = data_in;
      end else if (pend_q) begin
        disp_d = hold_q;
      end
      xfer_d = load | pend_q;
      pend_d = 1'b0;
    end

    char_d = char_q;
    if (slot_end) begin
      unique case (idx_d)
        2'd3:    char_d = disp_d[15:12];
        2'd2:    char_d = disp_d[11:8];
        2'd1:    char_d = disp_d[7:4];
        default: char_d = disp_d[3:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd3;
      disp_q <= 16'h0000;
      hold_q <= 16'h0000;
      pend_q <= 1'b0;
      xfer_q <= 1'b0;
      ack_q  <= 1'b0;
      char_q <= 4'h0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
      xfer_q <= xfer_d;
      ack_q  <= xfer_q;
      char_q <= char_d;
    end
  end

`ifdef HEX_SCAN_LZ_BLANK_EN
  logic blank;

  // Blank a digit when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    unique case (idx_q)
      2'd3:    blank = (disp_q[15:12] == 4'h0);
      2'd2:    blank = (disp_q[15:8] == 8'h00);
      2'd1:    blank = (disp_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  logic blank;
  assign blank = 1'b0;
`endif

  always_comb begin
    an = 4'b1111;
    if (cnt_q >= CntDead && !blank) begin
      an[idx_q] = 1'b0;
    end
  end

  // Gated by rst_n so the combinational strobe is low while reset is held.
  assign frame_start = rst_n && (cnt_q == '0) && (idx_q == 2'd3);
  assign load_ack    = ack_q;
  assign char        = char_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner with REFRESH_CYCLES=8, DEAD_CYCLES=2.
// Loads are queued with their expected frame boundary and retired when that frame begins.
module tb_hex_display_scanner;

  localparam int unsigned Refresh = 8;
  localparam int unsigned Dead    = 2;
  localparam int          Frame   = 4 * Refresh;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_start;

  hex_display_scanner #(
    .REFRESH_CYCLES(Refresh),
    .DEAD_CYCLES   (Dead)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load       (load),
    .load_ack   (load_ack),
    .char       (char),
    .an         (an),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          bnd;
    logic [15:0] val;
  } sb_item_t;

  sb_item_t    sb[$];
  int          n_cmp;
  int          n_err;
  int          cyc;
  int          ack_cycle;
  logic [15:0] exp_disp;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_push(input int c, input logic [15:0] v);
    int b;
    b = (c / Frame + 1) * Frame;
    if (sb.size() > 0 && sb[$].bnd == b) begin
      sb[$].val = v;
    end else begin
      sb.push_back('{bnd: b, val: v});
    end
  endtask

  task automatic check_cycle();
    int          digit;
    int          phase;
    logic [3:0]  exp_an;
    logic [15:0] upper;
    sb_item_t    it;
    if (sb.size() > 0 && sb[0].bnd == cyc) begin
      it        = sb.pop_front();
      exp_disp  = it.val;
      ack_cycle = cyc + 1;
    end
    phase  = cyc % Refresh;
    digit  = 3 - ((cyc / Refresh) % 4);
    upper  = exp_disp >> (4 * digit);
    exp_an = 4'b1111;
    if (phase >= Dead) exp_an[digit] = 1'b0;
`ifdef HEX_SCAN_LZ_BLANK_EN
    if (digit >= 1 && upper == 16'h0000) exp_an = 4'b1111;
`endif
    check_eq("an", 16'(an), 16'(exp_an));
    check_eq("char", 16'(char), upper & 16'h000f);
    check_eq("frame_start", 16'(frame_start), 16'(cyc % Frame == 0));
    check_eq("load_ack", 16'(load_ack), 16'(cyc == ack_cycle));
  endtask

  task automatic step(input logic ld, input logic [15:0] val);
    load    = ld;
    data_in = val;
    if (ld) sb_push(cyc, val);
    @(negedge clk);
    load = 1'b0;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  task automatic reset_dut(input int n);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_an", 16'(an), 16'h000f);
    check_eq("rst_char", 16'(char), 16'h0000);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("rst_an", 16'(an), 16'h000f);
      check_eq("rst_char", 16'(char), 16'h0000);
      check_eq("rst_ack", 16'(load_ack), 16'h0000);
      check_eq("rst_fs", 16'(frame_start), 16'h0000);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    exp_disp  = 16'h0000;
    ack_cycle = -1;
    cyc       = 0;
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    ack_cycle = -1;
    exp_disp  = 16'h0000;
    rst_n     = 1'b0;
    load      = 1'b0;
    data_in   = 16'h0000;

    reset_dut(3);
    idle(4);

    // Load mid-frame, visible at the next boundary.
    step(1'b1, 16'h1234);
    idle(60);

    // Two loads in one frame: last wins, single ack.
    step(1'b1, 16'hAAAA);
    idle(5);
    step(1'b1, 16'h5A5F);
    idle(70);

    // Load exactly on the boundary cycle takes the bypass path.
    while (cyc % Frame != Frame - 1) step(1'b0, 16'h0000);
    step(1'b1, 16'hBEEF);
    idle(70);

    // Leading zeros (blanked only when the macro is defined).
    step(1'b1, 16'h0050);
    idle(70);

    // Reset mid-slot discards a pending load.
    while (cyc % Frame != 3) step(1'b0, 16'h0000);
    step(1'b1, 16'h1357);
    idle(3);
    reset_dut(2);
    idle(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

- Time-multiplexes a 16-bit value (four hex characters) onto a four-digit common-anode seven-segment display.
- Sits directly upstream of the team's combinational hex-to-segment decoder: `char` drives the decoder's 4-bit character input, `an` drives the digit anodes.
- Adds per-digit refresh timing, an anode dead-time to suppress ghosting, and a frame-synchronous load handshake so displayed digits never tear mid-frame.

## Interface

Parameters:
- `REFRESH_CYCLES`, default 1024: clock cycles per digit slot; legal range ≥ 2.
- `DEAD_CYCLES`, default 16: cycles at the start of each slot during which all anodes are off; legal range 1 ≤ `DEAD_CYCLES` < `REFRESH_CYCLES`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in 16: value to display; [15:12] is the leftmost digit.
- `load` in 1: single-cycle request to capture `data_in`.
- `load_ack` out 1: one-cycle pulse when the captured value becomes visible.
- `char` out 4: nibble of the currently selected digit, to the decoder.
- `an` out 4: anodes, active-low; `an[3]` is the leftmost digit.
- `frame_start` out 1: high for the first cycle of the digit-3 slot.

## Operation

- Registers:
  - `cnt`: 0..`REFRESH_CYCLES`-1.
  - `idx`: 2 bits.
  - `disp`: 16 bits, the displayed value.
  - `hold`: 16 bits.
  - `pend`: 1 bit.
- Slot phases: `cnt` < `DEAD_CYCLES` is DEAD, so `an`=4'b1111. Otherwise it is ACTIVE: `an` is all ones except bit `idx`, which is 0.
- When `cnt` = `REFRESH_CYCLES`-1, `cnt` wraps to 0 and `idx` decrements modulo 4 (3→2→1→0→3).
- `char` is registered and equals `disp[4*idx+3 : 4*idx]` for the whole slot. It changes only at the slot boundary edge, i.e. during DEAD, never while an anode is lit.
- Load path:
  - `load`=1 sets `hold` ← `data_in` and `pend` ← 1.
  - Multiple loads within a frame: the last one wins, and only one ack is produced.
- Frame boundary is the edge where `idx` goes 0→3:
  - If `load`=1 on that cycle: `disp` ← `data_in` (bypass).
  - Else if `pend`=1: `disp` ← `hold`.
  - In either case `pend` ← 0 and `load_ack` pulses high on the following cycle for exactly one cycle.
  - No transfer means no ack.
- `frame_start` = 1 exactly when `idx`=3 and `cnt`=0.
- `load` is not gated by any ready signal; it is always accepted.

## Timing

- Reset values (asynchronous on `rst_n`=0):
  - `an`=4'b1111, `char`=4'h0, `load_ack`=0, `frame_start`=0.
  - `cnt`=0, `idx`=3, `disp`=16'h0000, `hold`=16'h0000, `pend`=0.
- First cycle after `rst_n` rises: `cnt`=0 and `idx`=3, so `frame_start`=1 and the DEAD phase is active.
- Frame period is 4×`REFRESH_CYCLES`. Each digit is lit for `REFRESH_CYCLES`−`DEAD_CYCLES` cycles.
- Load-to-visible latency: from the `load` edge to the next frame boundary, worst case 4×`REFRESH_CYCLES`. The new `char` appears in the first digit-3 slot, and `load_ack` follows the boundary by 1 cycle.
- Reset mid-operation: all outputs are forced to reset values immediately. A pending load is discarded with no ack.
- `cnt` width is `$clog2(REFRESH_CYCLES)`. `cnt` has no terminal overflow; it always wraps at `REFRESH_CYCLES`-1.

## Configuration

`HEX_SCAN_LZ_BLANK_EN`:

- Defined: leading-zero blanking.
  - During ACTIVE, digit `idx`'s anode stays high when `idx` ≥ 1 and every nibble of `disp` from `idx` up to 3 is 4'h0.
  - Digit 0 is always lit.
  - `char` still tracks `disp`.
- Undefined: all four digits are lit in their ACTIVE phase regardless of value.
- Timing, `frame_start` and the handshake are identical in both builds.

## Test plan

Run with `REFRESH_CYCLES`=8 and `DEAD_CYCLES`=2.

1. Reset, then release → `an`=1111 and `char`=0. `frame_start` is high in the first cycle and every 32 cycles thereafter. `an` sequence per slot: 2×1111, then 6×0111, 1011, 1101, 1110.
2. `load`=1 with `data_in`=16'h1234 at cycle 5 of a frame → `char` stays 0 until the boundary at cycle 32. `load_ack` is high at cycle 33 only. Then `char`=1, 2, 3, 4, 8 cycles each.
3. Two loads in one frame (16'hAAAA, then 16'h5A5F) → a single `load_ack`. The next frame shows `char` = 5, A, 5, F.
4. `load` with 16'hBEEF asserted exactly on the boundary cycle → that frame shows B, E, E, F. One ack follows the next cycle, and no extra ack occurs on the following boundary.
5. `disp`=16'h0050 → with the macro, the digit-3 and digit-2 slots keep `an`=1111 throughout, and the digit-1 and digit-0 slots light (showing 5 and 0). Without the macro, all four digits light.
6. `rst_n` pulsed low mid-slot after a pending load → `an`=1111 and `char`=0 the same cycle, no `load_ack` ever appears, and the display shows 0000.
